// File: rtl/window_vote_sequencer.sv
// Frame-level sequencer above the window-sliding core: launches one frame, tallies
// one-hot class votes per window and reports the majority class at end of frame.
module window_vote_sequencer #(
  parameter int NUM_WINDOWS    = 8325,
  parameter int NUM_CLASSES    = 10,
  parameter int COUNT_WIDTH    = 14,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CLS_W          = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [NUM_CLASSES-1:0] core_class,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] window_cnt,
  output logic                   result_valid,
  output logic [CLS_W-1:0]       result_class,
  output logic [COUNT_WIDTH-1:0] result_votes,
  output logic [2:0]             error
);

  localparam int                     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]        WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] WIN_LAST = COUNT_WIDTH'(NUM_WINDOWS);
  localparam logic [CLS_W-1:0]       IDX_LAST = CLS_W'(NUM_CLASSES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [NUM_CLASSES-1:0] ONE_V    = NUM_CLASSES'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_TALLY  = 3'd3,
    S_SCAN   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic is_onehot(input logic [NUM_CLASSES-1:0] v);
    return (v != '0) && ((v & (v - ONE_V)) == '0);
  endfunction

  // Only meaningful for a one-hot vector: ORs the index of every set bit.
  function automatic logic [CLS_W-1:0] onehot_index(input logic [NUM_CLASSES-1:0] v);
    logic [CLS_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      idx = idx | (v[i] ? CLS_W'(i) : '0);
    end
    return idx;
  endfunction

  state_e                                  state_q, state_d;
  logic [WD_W-1:0]                         wd_q, wd_d;
  logic [NUM_CLASSES-1:0]                  cls_q, cls_d;
  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0] votes_q, votes_d;
  logic [COUNT_WIDTH-1:0]                  win_q, win_d;
  logic [2:0]                              err_q, err_d;
  logic [CLS_W-1:0]                        idx_q, idx_d;
  logic [CLS_W-1:0]                        best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0]                  best_cnt_q, best_cnt_d;
  logic [CLS_W-1:0]                        res_class_q, res_class_d;
  logic [COUNT_WIDTH-1:0]                  res_votes_q, res_votes_d;
  logic [COUNT_WIDTH-1:0]                  win_inc_s;
  logic [CLS_W-1:0]                        vote_idx_s;
  logic [CLS_W-1:0]                        nb_idx_s;
  logic [COUNT_WIDTH-1:0]                  nb_cnt_s;

  // Next-state, tally, watchdog and scan datapath.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    cls_d       = cls_q;
    votes_d     = votes_q;
    win_d       = win_q;
    err_d       = err_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    res_class_d = res_class_q;
    res_votes_d = res_votes_q;
    win_inc_s   = win_q + COUNT_WIDTH'(1);
    vote_idx_s  = onehot_index(cls_q);
    nb_idx_s    = best_idx_q;
    nb_cnt_s    = best_cnt_q;

    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end else begin
      // A done pulse outside WAIT cannot be accepted; IDLE ignores it silently.
      if (core_done && (state_q != S_IDLE) && (state_q != S_WAIT)) begin
        err_d[2] = 1'b1;
      end else begin
        err_d[2] = err_q[2];
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_LAUNCH;
            votes_d    = '0;
            win_d      = '0;
            err_d      = 3'b000;
            wd_d       = '0;
            idx_d      = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LAUNCH: state_d = S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            cls_d   = core_class;
            wd_d    = '0;
            state_d = S_TALLY;
          end else if (wd_q == WD_LAST) begin
            err_d[0] = 1'b1;
            state_d  = S_SCAN;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_TALLY: begin
          win_d = win_inc_s;
          if (is_onehot(cls_q)) begin
            if (votes_q[vote_idx_s] != CNT_MAX) begin
              votes_d[vote_idx_s] = votes_q[vote_idx_s] + COUNT_WIDTH'(1);
            end else begin
              votes_d[vote_idx_s] = votes_q[vote_idx_s];
            end
          end else begin
            err_d[1] = 1'b1;
          end
          if (win_inc_s == WIN_LAST) begin
            state_d = S_SCAN;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_SCAN: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (votes_q[idx_q] > best_cnt_q) begin
            nb_idx_s = idx_q;
            nb_cnt_s = votes_q[idx_q];
          end else begin
            nb_idx_s = best_idx_q;
            nb_cnt_s = best_cnt_q;
          end
          best_idx_d = nb_idx_s;
          best_cnt_d = nb_cnt_s;
          if (idx_q == IDX_LAST) begin
            res_class_d = nb_idx_s;
            res_votes_d = nb_cnt_s;
            state_d     = S_DONE;
          end else begin
            idx_d = idx_q + CLS_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      cls_q       <= '0;
      votes_q     <= '0;
      win_q       <= '0;
      err_q       <= 3'b000;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      res_class_q <= '0;
      res_votes_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      cls_q       <= cls_d;
      votes_q     <= votes_d;
      win_q       <= win_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      res_class_q <= res_class_d;
      res_votes_q <= res_votes_d;
    end
  end

  assign core_start   = (state_q == S_LAUNCH);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign window_cnt   = win_q;
  assign result_class = res_class_q;
  assign result_votes = res_votes_q;
  assign error        = err_q;

endmodule

// File: tb/tb_window_vote_sequencer.sv
// Bench for window_vote_sequencer: directed frames with literal expectations plus
// random traffic, all checked every cycle against an abstract frame model.
module tb_window_vote_sequencer;

  localparam int NW = 4;
  localparam int NC = 4;
  localparam int CW = 14;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          core_done = 1'b0;
  logic [NC-1:0] core_class = '0;
  logic          core_start, busy, result_valid;
  logic [CW-1:0] window_cnt, result_votes;
  logic [1:0]    result_class;
  logic [2:0]    error;

  int n_tests = 0;
  int n_fail  = 0;

  window_vote_sequencer #(
    .NUM_WINDOWS(NW), .NUM_CLASSES(NC), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .core_start(core_start), .core_done(core_done), .core_class(core_class),
    .busy(busy), .window_cnt(window_cnt), .result_valid(result_valid),
    .result_class(result_class), .result_votes(result_votes), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract frame model ----------------
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_TALLY = 3, P_SCAN = 4, P_DONE = 5;
  int         m_ph = P_IDLE;
  int         m_votes[NC];
  int         m_win = 0;
  logic [2:0] m_err = 3'b000;
  int         m_quiet = 0;
  int         m_scan_left = 0;
  int         m_pend_cls = 0, m_pend_votes = 0;
  int         m_res_cls = 0, m_res_votes = 0;
  logic [NC-1:0] m_cap = '0;

  task automatic enter_scan();
    int best, bi;
    best = 0; bi = 0;
    for (int i = 0; i < NC; i++) if (m_votes[i] > best) begin best = m_votes[i]; bi = i; end
    m_pend_cls = bi; m_pend_votes = best;
    m_scan_left = NC;
    m_ph = P_SCAN;
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_win = 0; m_err = 3'b000; m_res_cls = 0; m_res_votes = 0;
    for (int i = 0; i < NC; i++) m_votes[i] = 0;
  endtask

  task automatic model_step();
    if (m_ph != P_IDLE && abort) begin
      m_ph = P_IDLE;
      return;
    end
    if (core_done && m_ph != P_IDLE && m_ph != P_WAIT) m_err[2] = 1'b1;
    case (m_ph)
      P_IDLE: if (start) begin
        for (int i = 0; i < NC; i++) m_votes[i] = 0;
        m_win = 0; m_err = 3'b000; m_ph = P_LAUNCH;
      end
      P_LAUNCH: begin m_ph = P_WAIT; m_quiet = 0; end
      P_WAIT: begin
        if (core_done) begin
          m_cap = core_class; m_ph = P_TALLY;
        end else begin
          m_quiet++;
          if (m_quiet == TO) begin m_err[0] = 1'b1; enter_scan(); end
        end
      end
      P_TALLY: begin
        if ($countones(m_cap) == 1) begin
          for (int i = 0; i < NC; i++)
            if (m_cap[i] && m_votes[i] < (1 << CW) - 1) m_votes[i]++;
        end else m_err[1] = 1'b1;
        m_win++;
        if (m_win == NW) enter_scan();
        else begin m_ph = P_WAIT; m_quiet = 0; end
      end
      P_SCAN: begin
        m_scan_left--;
        if (m_scan_left == 0) begin
          m_res_cls = m_pend_cls; m_res_votes = m_pend_votes; m_ph = P_DONE;
        end
      end
      P_DONE: m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
  endtask

  // Advance the model on each edge and compare every output shortly after.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("core_start",   core_start,   m_ph == P_LAUNCH);
    chk("busy",         busy,         m_ph != P_IDLE);
    chk("result_valid", result_valid, m_ph == P_DONE);
    chk("window_cnt",   window_cnt,   m_win);
    chk("result_class", result_class, m_res_cls);
    chk("result_votes", result_votes, m_res_votes);
    chk("error",        error,        m_err);
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic run_frame(input logic [15:0] classes, input int nwin, input int gap);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      repeat (gap) @(negedge clk);
      core_done = 1'b1; core_class = classes[w*4 +: 4];
      @(negedge clk);
      core_done = 1'b0; core_class = '0;
    end
  endtask

  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!result_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("result_valid_seen", result_valid, 1'b1);
  endtask

  int lat;
  logic seen_rv;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_window_cnt", window_cnt, 14'd0);
    chk("rst_error", error, 3'b000);
    rst = 1'b1;
    @(negedge clk);

    // Normal frame: 0010,0010,0001,0010
    run_frame({4'b0010, 4'b0001, 4'b0010, 4'b0010}, 4, 5);
    wait_result(lat);
    chk("normal_latency", lat, 6);
    chk("normal_class", result_class, 2'd1);
    chk("normal_votes", result_votes, 14'd3);
    chk("normal_wcnt", window_cnt, 14'd4);
    chk("normal_err", error, 3'b000);
    repeat (2) @(negedge clk);

    // Tie: 0001,0010,0010,0001
    run_frame({4'b0001, 4'b0010, 4'b0010, 4'b0001}, 4, 3);
    wait_result(lat);
    chk("tie_class", result_class, 2'd0);
    chk("tie_votes", result_votes, 14'd2);
    repeat (2) @(negedge clk);

    // Malformed: 0100,0000,0110,0100
    run_frame({4'b0100, 4'b0110, 4'b0000, 4'b0100}, 4, 2);
    wait_result(lat);
    chk("mal_class", result_class, 2'd2);
    chk("mal_votes", result_votes, 14'd2);
    chk("mal_wcnt", window_cnt, 14'd4);
    chk("mal_err", error, 3'b010);
    repeat (2) @(negedge clk);

    // Timeout after two windows of class 3
    run_frame({8'h00, 4'b1000, 4'b1000}, 2, 4);
    wait_result(lat);
    chk("to_class", result_class, 2'd3);
    chk("to_votes", result_votes, 14'd2);
    chk("to_wcnt", window_cnt, 14'd2);
    chk("to_err", error, 3'b001);
    repeat (2) @(negedge clk);

    // Reset in WAIT after two windows
    run_frame({8'h00, 4'b0001, 4'b0010}, 2, 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_wcnt", window_cnt, 14'd0);
    chk("mrst_class", result_class, 2'd0);
    chk("mrst_votes", result_votes, 14'd0);
    chk("mrst_rv", result_valid, 1'b0);
    chk("mrst_cs", core_start, 1'b0);
    chk("mrst_err", error, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame({4'b0010, 4'b0001, 4'b0010, 4'b0010}, 4, 5);
    wait_result(lat);
    chk("post_rst_class", result_class, 2'd1);
    chk("post_rst_votes", result_votes, 14'd3);
    repeat (2) @(negedge clk);

    // Overrun, start while busy, abort in WAIT
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    core_done = 1'b1; core_class = 4'b0001;
    repeat (2) @(negedge clk);
    core_done = 1'b0; core_class = '0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("ovr_cs_ignored", core_start, 1'b0);
    repeat (2) @(negedge clk);
    chk("ovr_err", error, 3'b100);
    chk("ovr_wcnt", window_cnt, 14'd1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    seen_rv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_rv = seen_rv | result_valid;
    end
    chk("abort_no_rv", seen_rv, 1'b0);
    chk("abort_wcnt_held", window_cnt, 14'd1);

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(7, 0) == 0);
      abort = ($urandom_range(99, 0) == 0);
      if ((c % 300) < 45) core_done = 1'b0;
      else if (core_done) core_done = ($urandom_range(7, 0) == 0);
      else core_done = ($urandom_range(2, 0) == 0);
      if ($urandom_range(3, 0) != 0) core_class = 4'b0001 << $urandom_range(3, 0);
      else core_class = 4'($urandom_range(15, 0));
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; core_done = 1'b0; core_class = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_vote_sequencer.md
# window_vote_sequencer

Frame-level controller that sits above `neuralcore`. It launches one frame of window sliding, counts per-window classification pulses, and accumulates one vote counter per class from the one-hot class vector. At end of frame it scans the counters and reports the majority class. Its outputs drive the core's `ws_start`; its inputs come from the core's `done` / `calcOutput`.

## Interface
Parameters:
- `NUM_WINDOWS`, default 8325: windows per frame, (200-16+1)*(60-16+1).
- `NUM_CLASSES`, default 10: class-vector width; must be ≥2.
- `COUNT_WIDTH`, default 14: width of window and vote counters; must hold `NUM_WINDOWS`.
- `TIMEOUT_CYCLES`, default 65535: per-window watchdog limit.
- `CLS_W`, default `$clog2(NUM_CLASSES)`: class index width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  synchronous frame cancel.
- `core_start`  out  1  one-cycle launch pulse to `ws_start`.
- `core_done`  in  1  one-cycle per-window completion pulse.
- `core_class`  in  NUM_CLASSES  one-hot class vector, valid with `core_done`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `window_cnt`  out  COUNT_WIDTH  windows accepted this frame.
- `result_valid`  out  1  one-cycle result strobe.
- `result_class`  out  CLS_W  majority class index.
- `result_votes`  out  COUNT_WIDTH  vote count of `result_class`.
- `error`  out  3  sticky per frame: [0] timeout, [1] malformed class vector, [2] overrun.

## Operation
- States: IDLE, LAUNCH, WAIT, TALLY, SCAN, DONE. `core_start` = (state==LAUNCH). `result_valid` = (state==DONE). `busy` = (state≠IDLE). All are decoded from the state register, so they are glitch-free registered outputs.
- IDLE: on `start`=1, clear all vote counters, `window_cnt`, `error`, and the watchdog, then go to LAUNCH. `start` is ignored in every other state.
- LAUNCH: one cycle, then go to WAIT. The core slides windows by itself, so there is exactly one `core_start` per frame.
- WAIT: the watchdog increments each cycle. On `core_done`=1, capture `core_class`, clear the watchdog, and go to TALLY. If the watchdog reaches `TIMEOUT_CYCLES`-1 with no done, set `error[0]` and go to SCAN with partial counts.
- TALLY:
  - If the captured vector is exactly one-hot, increment that class's counter. Counters saturate at all-ones.
  - Otherwise (zero or multi-hot), add no vote and set `error[1]`.
  - `window_cnt` increments in both cases.
  - If the new `window_cnt` equals `NUM_WINDOWS`, go to SCAN; else go to WAIT.
- SCAN: visit indices 0..NUM_CLASSES-1, one per cycle. The running best is replaced only on a strictly greater count, so ties resolve to the lowest index. On the last index, latch `result_class` and `result_votes`, then go to DONE.
- DONE: one cycle, then go to IDLE. `result_class`, `result_votes`, `window_cnt`, and `error` hold until the next accepted `start`.
- `core_done`=1 in any state other than WAIT (LAUNCH, TALLY, SCAN, DONE) is dropped and sets `error[2]`. In IDLE it is ignored with no error.
- `abort`=1 in any non-IDLE state forces IDLE next cycle, with no `result_valid`. Counters are left as-is until the next `start`. `abort` has priority over all other transitions.
- `rst`=0 at any time, asynchronously: state=IDLE; all counters, results, and `error` cleared; all outputs 0.

## Timing
- Reset values: `core_start`=0, `busy`=0, `window_cnt`=0, `result_valid`=0, `result_class`=0, `result_votes`=0, `error`=0.
- `start` sampled at edge k: `core_start` and `busy` are high in cycle k+1, and `core_start` is low from k+2.
- `core_done` sampled at edge d: the vote is visible on the counter and `window_cnt` after edge d+1.
- Consecutive `core_done` pulses must be ≥2 cycles apart; a pulse landing in TALLY is an overrun.
- From the last `core_done` at edge d: SCAN occupies cycles d+2..d+1+NUM_CLASSES, and `result_valid` is high in cycle d+2+NUM_CLASSES. Latency is NUM_CLASSES+2 cycles.
- `busy` falls the cycle after DONE.

## Test plan
Bench parameters: `NUM_WINDOWS`=4, `NUM_CLASSES`=4, `TIMEOUT_CYCLES`=32.
- Reset mid-frame: assert `rst`=0 during WAIT after 2 windows → all outputs 0 immediately; the next `start` yields a normal frame.
- Normal frame: `core_class` = 0010, 0010, 0001, 0010 with 5-cycle gaps → one `core_start`; `result_valid` 6 cycles after the last done; `result_class`=1, `result_votes`=3, `window_cnt`=4, `error`=000.
- Tie: classes 0001, 0010, 0010, 0001 → `result_class`=0, `result_votes`=2.
- Malformed: classes 0100, 0000, 0110, 0100 → `result_class`=2, `result_votes`=2, `window_cnt`=4, `error`=010.
- Timeout: two dones (1000, 1000), then silence → `error[0]` set 32 cycles after the second done; `result_valid` with `result_class`=3, `result_votes`=2, `window_cnt`=2.
- Overrun and abort: `core_done` on consecutive cycles → `error[2]`=1 and the second vote is dropped. `start` pulsed while busy is ignored. `abort` during WAIT → IDLE next cycle with no `result_valid`.
